// File: rtl/sparse_pe.sv
// 2:4 structured-sparse dot-product processing element.
// Picks two activations by bitmask, multiplies each by its weight and sums the products; 2-cycle latency.
module sparse_pe #(
  parameter int ACT_W = 4,
  parameter int WGT_W = 8,
  parameter int OUT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4*ACT_W-1:0]   packed_activations,
  input  logic [3:0]           mask,
  input  logic [WGT_W-1:0]     weight_top,
  input  logic [WGT_W-1:0]     weight_bot,
  output logic [OUT_W-1:0]     result
);

  localparam int PROD_W = ACT_W + WGT_W;
  localparam int SUM_W  = PROD_W + 1;

  logic [ACT_W-1:0]  act [4];
  logic [ACT_W-1:0]  a_top;
  logic [ACT_W-1:0]  a_bot;
  logic              found_top;
  logic              found_bot;
  logic [PROD_W-1:0] p_top_next;
  logic [PROD_W-1:0] p_bot_next;
  logic [PROD_W-1:0] p_top_reg;
  logic [PROD_W-1:0] p_bot_reg;
  logic [SUM_W-1:0]  sum_next;
  logic [OUT_W-1:0]  result_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_unpack
      assign act[gi] = packed_activations[gi*ACT_W +: ACT_W];
    end
  endgenerate

  // Scan from bit 0 upward: first set bit feeds the top weight, second feeds the bottom weight.
  // Unused operands stay zero, so single-bit and empty masks fall out naturally.
  always_comb begin
    a_top     = '0;
    a_bot     = '0;
    found_top = 1'b0;
    found_bot = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) begin
        if (!found_top) begin
          a_top     = act[k];
          found_top = 1'b1;
        end else if (!found_bot) begin
          a_bot     = act[k];
          found_bot = 1'b1;
        end
      end
    end
  end

  assign p_top_next = PROD_W'(a_top) * PROD_W'(weight_top);
  assign p_bot_next = PROD_W'(a_bot) * PROD_W'(weight_bot);
  assign sum_next   = SUM_W'(p_top_reg) + SUM_W'(p_bot_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_top_reg  <= '0;
      p_bot_reg  <= '0;
      result_reg <= '0;
    end else begin
      p_top_reg  <= p_top_next;
      p_bot_reg  <= p_bot_next;
      result_reg <= OUT_W'(sum_next);
    end
  end

  assign result = result_reg;

endmodule

// File: tb/tb_sparse_pe.sv
// Self-checking bench for sparse_pe: vector table, degenerate masks, async reset and random 2:4 stream.
// Expected results ride a scoreboard queue tagged with the cycle they are due at the output.
module tb_sparse_pe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] packed_activations = '0;
  logic [3:0]  mask = '0;
  logic [7:0]  weight_top = '0;
  logic [7:0]  weight_bot = '0;
  logic [31:0] result;

  sparse_pe dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .packed_activations (packed_activations),
    .mask               (mask),
    .weight_top         (weight_top),
    .weight_bot         (weight_bot),
    .result             (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [31:0] exp;
    string       name;
  } sb_t;

  typedef struct {
    logic [15:0] acts;
    logic [3:0]  m;
    logic [7:0]  t;
    logic [7:0]  b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  sb_t         sb_q[$];
  sb_t         sb_e;
  vec_t        vecs[10];
  int unsigned cycle  = 0;
  int          checks = 0;
  int          passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: result=%0d (0x%08h) expected=%0d", name, act, act, exp);
  endtask

  // Apply one input set (caller is at a negedge) and schedule its expected output two edges later.
  task automatic drive(input logic [15:0] acts, input logic [3:0] m, input logic [7:0] t,
                       input logic [7:0] b, input logic [31:0] exp, input string name);
    packed_activations = acts;
    mask               = m;
    weight_top         = t;
    weight_bot         = b;
    sb_q.push_back('{due: cycle + 2, exp: exp, name: name});
    $display("drive %-12s acts=%04h mask=%04b top=%0d bot=%0d exp=%0d due=%0d",
             name, acts, m, t, b, exp, cycle + 2);
  endtask

  // Reset pulse between edges: anything already sampled is discarded, the bus value is not.
  task automatic mid_reset();
    sb_t e;
    int  n;
    #2 rst_n = 1'b0;
    #1 check("rst_async_zero", result, 32'd0);
    n = sb_q.size();
    repeat (n) begin
      e = sb_q.pop_front();
      if (e.due >= cycle + 2) sb_q.push_back(e);
    end
    #1 rst_n = 1'b1;
    check("rst_release_zero", result, 32'd0);
    @(posedge clk);
    #1 check("post_rst_bubble", result, 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cycle++;
      #1;
      while (sb_q.size() > 0 && sb_q[0].due <= cycle) begin
        sb_e = sb_q.pop_front();
        check(sb_e.name, result, sb_e.exp);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, result=%0d expected completion", result);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{16'h4321, 4'b0011, 8'd10,  8'd20,  32'd50,   "adj_0011"};
    vecs[1] = '{16'h8765, 4'b1010, 8'd3,   8'd4,   32'd50,   "gap_1010"};
    vecs[2] = '{16'h8765, 4'b0101, 8'd3,   8'd4,   32'd43,   "gap_0101"};   // 5*3 + 7*4
    vecs[3] = '{16'hFFFF, 4'b1100, 8'd255, 8'd255, 32'd7650, "max_1100"};
    vecs[4] = '{16'h8765, 4'b0000, 8'd3,   8'd4,   32'd0,    "mask_0000"};
    vecs[5] = '{16'h8765, 4'b0100, 8'd3,   8'd4,   32'd21,   "mask_0100"};
    vecs[6] = '{16'h8765, 4'b1111, 8'd3,   8'd4,   32'd39,   "mask_1111"};
    vecs[7] = '{16'h8765, 4'b1000, 8'd3,   8'd4,   32'd24,   "mask_1000"};
    vecs[8] = '{16'h8765, 4'b1101, 8'd3,   8'd4,   32'd43,   "mask_1101"};
    vecs[9] = '{16'h8765, 4'b0110, 8'd9,   8'd200, 32'd1454, "mask_0110"};  // 6*9 + 7*200

    // Reset held with toggling inputs: output must stay zero.
    repeat (6) begin
      @(negedge clk);
      packed_activations = 16'($urandom);
      mask               = 4'($urandom);
      weight_top         = 8'($urandom);
      weight_bot         = 8'($urandom);
      #1 check("rst_hold", result, 32'd0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Back-to-back table vectors; the first cycle after the first sample still reads zero.
    @(negedge clk);
    sb_q.push_back('{due: cycle + 1, exp: 32'd0, name: "pre_first"});
    drive(vecs[0].acts, vecs[0].m, vecs[0].t, vecs[0].b, vecs[0].exp, vecs[0].name);
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].acts, vecs[i].m, vecs[i].t, vecs[i].b, vecs[i].exp, vecs[i].name);
    end

    // Mid-stream reset: last pre-reset input is lost, the bus value at release is the first result.
    @(negedge clk);
    drive(16'h4321, 4'b0011, 8'd10, 8'd20, 32'd50, "pre_rst");
    @(negedge clk);
    drive(16'hFFFF, 4'b1100, 8'd255, 8'd255, 32'd7650, "lost_rst");
    @(negedge clk);
    drive(16'h8765, 4'b1010, 8'd3, 8'd4, 32'd50, "first_post");
    mid_reset();
    @(negedge clk);
    drive(16'h8765, 4'b0101, 8'd3, 8'd4, 32'd43, "second_post");

    // Random 2:4 stream; expected value built from the chosen indices, not from the mask.
    for (int n = 0; n < 10000; n++) begin
      int unsigned i0, i1;
      logic [15:0] a;
      logic [7:0]  t, b;
      logic [31:0] e;
      i0 = $urandom_range(0, 2);
      i1 = $urandom_range(i0 + 1, 3);
      a  = 16'($urandom);
      t  = 8'($urandom);
      b  = 8'($urandom);
      e  = 32'(a[4*i0 +: 4]) * 32'(t) + 32'(a[4*i1 +: 4]) * 32'(b);
      @(negedge clk);
      drive(a, 4'((1 << i0) | (1 << i1)), t, b, e, "rand");
    end

    repeat (4) @(negedge clk);
    checks++;
    if (sb_q.size() == 0) passes++;
    else $display("FAIL drain: pending=%0d required=0", sb_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
